// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter: grants one of two requesters per cycle into a registered register-file write port.
// Optional feature: define WB_ARB_RR_EN for round-robin arbitration (default build is fixed priority, requester 0 first).
module regs_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_hold,
    input  logic        v0,
    input  logic [4:0]  addr0,
    input  logic [31:0] data0,
    output logic        rdy0,
    input  logic        v1,
    input  logic [4:0]  addr1,
    input  logic [31:0] data1,
    output logic        rdy1,
    output logic        L_S,
    output logic [4:0]  Wt_addr,
    output logic [31:0] Wt_data,
    output logic [15:0] wb_cnt
);

    logic        grant_ok;
    logic        gnt0;
    logic        gnt1;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Reset is folded in combinationally so no handshake can complete on a reset edge.
    assign grant_ok = rst & ~wb_hold;

`ifdef WB_ARB_RR_EN
    logic rr_ptr;   // 0: requester 0 favoured on a tie, 1: requester 1 favoured

    always_comb begin
        gnt0 = grant_ok & v0 & (~v1 | ~rr_ptr);
        gnt1 = grant_ok & v1 & (~v0 | rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    always_comb begin
        gnt0 = grant_ok & v0;
        gnt1 = grant_ok & v1 & ~v0;
    end
`endif

    assign rdy0     = gnt0;
    assign rdy1     = gnt1;
    assign xfer     = gnt0 | gnt1;
    assign sel_addr = gnt1 ? addr1 : addr0;
    assign sel_data = gnt1 ? data1 : data0;

    // Register 0 is hard-wired: the handshake completes but no write is enabled or counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            L_S     <= 1'b0;
            Wt_addr <= 5'd0;
            Wt_data <= 32'd0;
            wb_cnt  <= 16'd0;
        end else if (xfer) begin
            L_S     <= (sel_addr != 5'd0);
            Wt_addr <= sel_addr;
            Wt_data <= sel_data;
            if (sel_addr != 5'd0) begin
                wb_cnt <= wb_cnt + 16'd1;
            end
        end else begin
            L_S <= 1'b0;
        end
    end

endmodule

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wb_hold  in  1  pipeline stall; blocks all grants while 1.
- v0  in  1  requester 0 (ALU) write-back valid.
- addr0  in  5  requester 0 destination register.
- data0  in  32  requester 0 write data.
- rdy0  out  1  requester 0 grant; combinational.
- v1  in  1  requester 1 (MDU/load) write-back valid.
- addr1  in  5  requester 1 destination register.
- data1  in  32  requester 1 write data.
- rdy1  out  1  requester 1 grant; combinational.
- L_S  out  1  register-file write enable; registered.
- Wt_addr  out  5  register-file write address; registered.
- Wt_data  out  32  register-file write data; registered.
- wb_cnt  out  16  committed-write counter; registered.

Function
REQ-002 A transfer on requester n SHALL occur in a cycle when vn=1 and rdyn=1 at the rising clk edge.
REQ-003 At most one of rdy0 and rdy1 SHALL be 1 in any cycle.
REQ-004 rdy0 and rdy1 SHALL both be 0 while wb_hold=1 or rst=0.
REQ-005 rdyn SHALL be 0 whenever vn=0.
REQ-006 With only one valid requester, that requester SHALL be granted in the same cycle.
REQ-007 With both valid, the winner SHALL be chosen by the arbitration policy in REQ-019 and REQ-020.
REQ-008 A transfer at edge N SHALL present the transferred address and data on Wt_addr/Wt_data after edge N, with L_S=1; latency is 1 cycle.
REQ-009 A transfer with address 0 SHALL complete the handshake but SHALL drive L_S=0; Wt_addr/Wt_data still update.
REQ-010 In a cycle with no transfer, L_S SHALL be 0 after the edge; Wt_addr/Wt_data SHALL hold their values.
REQ-011 wb_cnt SHALL increment by 1 on each edge where L_S is driven to 1, wrapping 0xFFFF->0x0000.
REQ-012 The losing requester SHALL keep vn/addrn/datan stable until granted; the block does not buffer unaccepted requests.
REQ-013 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-014 When wb_hold is deasserted, grants SHALL resume in that same cycle.

Reset
REQ-015 While rst=0 at an edge, the block SHALL drive L_S=0, Wt_addr=0, Wt_data=0, and wb_cnt=0, and SHALL point the round-robin pointer at requester 0.
REQ-016 No transfer SHALL occur in a reset cycle, because rdy0 and rdy1 are forced to 0.
REQ-017 A write already registered before reset SHALL be cleared by the reset edge.
REQ-018 Normal arbitration SHALL begin in the first cycle with rst=1.

Configuration
REQ-019 With macro WB_ARB_RR_EN defined, arbitration SHALL be round-robin:
- A pointer favours requester 0 after reset.
- After each transfer, the pointer favours the requester that was not granted.
- The pointer changes only on a transfer.
REQ-020 Without WB_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning a tie; there SHALL be no pointer state.

Verification
REQ-021 Bench SHALL cover:
- Single write: rst 0->1, v0=1, addr0=5, data0=0x12345678 for 1 cycle -> rdy0=1 that cycle; next cycle L_S=1, Wt_addr=5, Wt_data=0x12345678, wb_cnt=1.
- Tie: v0=v1=1, addr0=6/0x87654321, addr1=7/0xCAFEF00D held 4 cycles -> with WB_ARB_RR_EN, grants alternate 0,1,0,1; without it, rdy0=1 for all 4 cycles and rdy1=0.
- Register 0: v1=1, addr1=0, data1=0xFFFFFFFF -> rdy1=1; next cycle L_S=0, wb_cnt unchanged.
- Hold: wb_hold=1 for 3 cycles with v0=1 -> rdy0=0 and L_S=0 throughout; wb_hold->0 -> rdy0=1 in that same cycle.
- Reset mid-operation: continuous v0 writes, rst=0 for 1 cycle -> rdy0=0 in that cycle; next cycle L_S=0, Wt_addr=0, Wt_data=0, wb_cnt=0; writes resume the cycle after.
- Wrap: preload wb_cnt to 0xFFFF by 65535 writes, then 1 more write -> wb_cnt=0x0000.
